// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared constants for the pipeline hazard/forwarding controller:
//   REG_AW          - default register address width
//   RESULTSRC_LOAD  - resultsrc encoding that marks a load
//   FWD_*           - EX operand mux select encodings
//   fwd_sel()       - priority encoder turning stage hits into a select
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,   // operand from register file read
        FWD_WB  = 2'b01,   // operand from writeback result
        FWD_MEM = 2'b10    // operand from memory-stage ALU result
    } fwd_sel_e;

    // The younger producer (MEM) holds the most recent value of the register,
    // so it takes priority over WB when both write the same address.
    function automatic fwd_sel_e fwd_sel(input logic hit_m, input logic hit_w);
        if (hit_m) begin
            return FWD_MEM;
        end else if (hit_w) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// -----------------------------------------------------------------------------
// hazard_shadow_pipe
// Shadow copy of the register-address fields of the EX, MEM and WB stages,
// advancing in lockstep with the real pipeline. EX can be replaced by a bubble.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   bubble_e             load a bubble into EX instead of the decode fields
//   valid_d              decode holds a real instruction
//   rs1_d/rs2_d/rd_d     decode register addresses
//   regwrite_d           decode instruction writes rd
//   resultsrc_d          decode result source (load detection)
//   rs1_e/rs2_e/rd_e     EX stage addresses
//   regwrite_e/is_load_e EX stage write enable / load flag
//   rd_m/regwrite_m      MEM stage destination / write enable
//   rd_w/regwrite_w      WB stage destination / write enable
//
// Naming: <sig>_q is the flop, <sig>_d its next value (so rs1_e_d is the next
// EX-stage rs1, distinct from the decode-stage input rs1_d).
// -----------------------------------------------------------------------------
module hazard_shadow_pipe
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = hazard_ctrl_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bubble_e,
    input  logic              valid_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              regwrite_d,
    input  logic [1:0]        resultsrc_d,
    output logic [REG_AW-1:0] rs1_e,
    output logic [REG_AW-1:0] rs2_e,
    output logic [REG_AW-1:0] rd_e,
    output logic              regwrite_e,
    output logic              is_load_e,
    output logic [REG_AW-1:0] rd_m,
    output logic              regwrite_m,
    output logic [REG_AW-1:0] rd_w,
    output logic              regwrite_w
);

    logic [REG_AW-1:0] rs1_e_q, rs1_e_d;
    logic [REG_AW-1:0] rs2_e_q, rs2_e_d;
    logic [REG_AW-1:0] rd_e_q, rd_e_d;
    logic              regwrite_e_q, regwrite_e_d;
    logic              is_load_e_q, is_load_e_d;
    logic [REG_AW-1:0] rd_m_q, rd_m_d;
    logic              regwrite_m_q, regwrite_m_d;
    logic              is_load_m_q, is_load_m_d;
    logic [REG_AW-1:0] rd_w_q, rd_w_d;
    logic              regwrite_w_q, regwrite_w_d;
    logic              is_load_w_q, is_load_w_d;

    // NOTE: every next-state signal gets a value on every path through this
    // block (bubble first, decode override second), so no latch is inferred.
    always_comb begin
        rs1_e_d      = '0;
        rs2_e_d      = '0;
        rd_e_d       = '0;
        regwrite_e_d = 1'b0;
        is_load_e_d  = 1'b0;
        if (!bubble_e) begin
            rs1_e_d      = rs1_d;
            rs2_e_d      = rs2_d;
            rd_e_d       = rd_d;
            // An invalid decode slot must never look like a producer later on.
            regwrite_e_d = regwrite_d & valid_d;
            is_load_e_d  = (resultsrc_d == RESULTSRC_LOAD) & valid_d;
        end

        rd_m_d       = rd_e_q;
        regwrite_m_d = regwrite_e_q;
        is_load_m_d  = is_load_e_q;

        rd_w_d       = rd_m_q;
        regwrite_w_d = regwrite_m_q;
        is_load_w_d  = is_load_m_q;
    end

    // NOTE: state flops use non-blocking assignments so all three stages
    // shift on the same edge from their pre-edge values. The shadow is a
    // handful of flops, not a memory, so every bit is reset to a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_e_q      <= '0;
            rs2_e_q      <= '0;
            rd_e_q       <= '0;
            regwrite_e_q <= 1'b0;
            is_load_e_q  <= 1'b0;
            rd_m_q       <= '0;
            regwrite_m_q <= 1'b0;
            is_load_m_q  <= 1'b0;
            rd_w_q       <= '0;
            regwrite_w_q <= 1'b0;
            is_load_w_q  <= 1'b0;
        end else begin
            rs1_e_q      <= rs1_e_d;
            rs2_e_q      <= rs2_e_d;
            rd_e_q       <= rd_e_d;
            regwrite_e_q <= regwrite_e_d;
            is_load_e_q  <= is_load_e_d;
            rd_m_q       <= rd_m_d;
            regwrite_m_q <= regwrite_m_d;
            is_load_m_q  <= is_load_m_d;
            rd_w_q       <= rd_w_d;
            regwrite_w_q <= regwrite_w_d;
            is_load_w_q  <= is_load_w_d;
        end
    end

    assign rs1_e      = rs1_e_q;
    assign rs2_e      = rs2_e_q;
    assign rd_e       = rd_e_q;
    assign regwrite_e = regwrite_e_q;
    assign is_load_e  = is_load_e_q;
    assign rd_m       = rd_m_q;
    assign regwrite_m = regwrite_m_q;
    assign rd_w       = rd_w_q;
    assign regwrite_w = regwrite_w_q;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard and forwarding controller for the 5-stage RISC-V pipeline. Detects
// load-use hazards in decode, resolves taken-branch flushes, selects EX
// operand forwarding, and counts stall/flush events for bring-up.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   valid_d                decode holds a real instruction
//   rs1_d/rs2_d/rd_d       decode register addresses
//   use_rs1_d/use_rs2_d    decode instruction reads rs1/rs2
//   regwrite_d             decode instruction writes rd
//   resultsrc_d            decode result source (2'b01 = load)
//   pcsrc_e                taken branch/jump resolved in EX
//   stall_f/stall_d        hold PC / hold IF/ID
//   flush_d/flush_e        clear IF/ID / bubble ID/EX
//   forward_a_e/b_e        EX operand A/B mux selects
//   stall_cnt/flush_cnt    saturating load-use stall / branch flush counters
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = hazard_ctrl_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              use_rs1_d,
    input  logic              use_rs2_d,
    input  logic              regwrite_d,
    input  logic [1:0]        resultsrc_d,
    input  logic              pcsrc_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [REG_AW-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic              regwrite_e, is_load_e, regwrite_m, regwrite_w;
    logic              lu;
    logic              m_valid, w_valid;

    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    hazard_shadow_pipe #(
        .REG_AW (REG_AW)
    ) u_shadow (
        .clk         (clk),
        .rst_n       (rst_n),
        .bubble_e    (flush_e),
        .valid_d     (valid_d),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .rd_d        (rd_d),
        .regwrite_d  (regwrite_d),
        .resultsrc_d (resultsrc_d),
        .rs1_e       (rs1_e),
        .rs2_e       (rs2_e),
        .rd_e        (rd_e),
        .regwrite_e  (regwrite_e),
        .is_load_e   (is_load_e),
        .rd_m        (rd_m),
        .regwrite_m  (regwrite_m),
        .rd_w        (rd_w),
        .regwrite_w  (regwrite_w)
    );

    always_comb begin
        // A load in EX has no data until MEM, so a dependent decode
        // instruction must wait one cycle. x0 never carries a dependency.
        lu = is_load_e && regwrite_e && (rd_e != '0) && valid_d &&
             ((use_rs1_d && (rs1_d == rd_e)) || (use_rs2_d && (rs2_d == rd_e)));

        // A taken branch makes the decode instruction wrong-path: squash it
        // rather than stall for it.
        stall_f = lu && !pcsrc_e;
        stall_d = lu && !pcsrc_e;
        flush_d = pcsrc_e;
        flush_e = pcsrc_e || lu;

        m_valid = regwrite_m && (rd_m != '0);
        w_valid = regwrite_w && (rd_w != '0);

        forward_a_e = fwd_sel(m_valid && (rd_m == rs1_e), w_valid && (rd_w == rs1_e));
        forward_b_e = fwd_sel(m_valid && (rd_m == rs2_e), w_valid && (rd_w == rs2_e));
    end

    // Bring-up counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_d && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (pcsrc_e && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
